// File: rtl/seq_shift_add_multiplier_if.sv
// Start/busy/done handshake and operand/product bus for seq_shift_add_multiplier.
interface seq_shift_add_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   Product;

  modport master (output start, A, B, input busy, done, Product);
  modport slave  (input start, A, B, output busy, done, Product);
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle unsigned shift-add multiplier; one ripple-carry add per clock,
// WIDTH iterations, registered 2*WIDTH-bit product.
module full_adder_1_bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);
  assign Sum   = A ^ B ^ Cin;
  assign Carry = (A & B) | (Cin & (A ^ B));
endmodule

module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  seq_shift_add_multiplier_if.slave    bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic [WIDTH:0]       carry;
  logic [2*WIDTH-1:0]   p_shift;

  // Ripple-carry add of the upper half of P and the gated multiplicand.
  assign addend   = p_q[0] ? m_q : '0;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder_1_bit u_fa (
      .A     (p_q[WIDTH+i]),
      .B     (addend[i]),
      .Cin   (carry[i]),
      .Sum   (sum[i]),
      .Carry (carry[i+1])
    );
  end

  // Top carry-out becomes the new MSB, so no product bit is ever dropped.
  assign p_shift = {carry[WIDTH], sum, p_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      p_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m_d     = bus.A;
          p_d     = {{WIDTH{1'b0}}, bus.B};
          count_d = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        p_d     = p_shift;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          product_d = p_shift;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.Product = product_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier (WIDTH=8).
module tb_seq_shift_add_multiplier;
  localparam int unsigned W = 8;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] last_prod = '0;
  sb_t  sb[$];

  seq_shift_add_multiplier_if #(.WIDTH(W)) bus ();

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Entered and left at a negedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    sb_t e;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    e.prod    = 32'(a) * 32'(b);
    e.cyc     = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    check("busy_rise", 32'(bus.busy), 32'd1);
    check("hold_calc", 32'(bus.Product), last_prod);
  endtask

  task automatic finish_op(input bit poke_in_done);
    int  n = 0;
    sb_t e;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      check("done_timeout", 32'(bus.done), 32'd1);
    end else if (sb.size() == 0) begin
      check("unexpected_done", 32'(bus.done), 32'd0);
    end else begin
      e = sb.pop_front();
      check("product", 32'(bus.Product), e.prod);
      check("latency", 32'(cyc - e.cyc), 32'(W + 1));
      check("busy_in_done", 32'(bus.busy), 32'd1);
      if (poke_in_done) begin
        bus.start = 1'b1;
        bus.A     = 8'd7;
        bus.B     = 8'd7;
      end
      last_prod = e.prod;
      @(negedge clk);
      bus.start = 1'b0;
      check("done_pulse", 32'(bus.done), 32'd0);
      check("busy_fall", 32'(bus.busy), 32'd0);
      check("hold_idle", 32'(bus.Product), last_prod);
    end
  endtask

  task automatic watch_no_done(input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("no_done", 32'(seen), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int c0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_prod", 32'(bus.Product), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(8'd3, 8'd5);     finish_op(1'b0);
    start_op(8'd255, 8'd255); finish_op(1'b0);
    start_op(8'd0, 8'd200);   finish_op(1'b0);
    start_op(8'd200, 8'd0);   finish_op(1'b0);

    // Requests during CALC and DONE must be ignored.
    start_op(8'd12, 8'd10);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'd7;
    bus.B     = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    finish_op(1'b1);
    watch_no_done(12);
    check("hold_after_ignored", 32'(bus.Product), 32'd120);

    // Asynchronous reset mid-operation.
    start_op(8'd9, 8'd9);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_prod", 32'(bus.Product), 32'd0);
    sb.delete();
    last_prod = '0;
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done(15);
    start_op(8'd6, 8'd7);     finish_op(1'b0);

    // Back-to-back: restart in the first IDLE cycle.
    c0 = cyc;
    start_op(8'd100, 8'd3);   finish_op(1'b0);
    check("spacing", 32'(cyc - c0), 32'(W + 2));
    start_op(8'd17, 8'd13);   finish_op(1'b0);

    for (int i = 0; i < 4; i++) begin
      start_op(W'($urandom), W'($urandom));
      finish_op(1'b0);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
